// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: two-requester round-robin arbiter/sequencer for a single-port sync-read RAM.
// Optional power-up RAM clear sequence enabled by defining RAM_ARB_CLR_EN.
`default_nettype none

module ram_sp_arbiter #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] din0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DWIDTH-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] din1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata1,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              busy
);

    localparam int DEPTH = 1 << AWIDTH;

    logic              last_gnt_q, last_gnt_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              in_clear;
    logic [AWIDTH-1:0] clr_addr;

`ifdef RAM_ARB_CLR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AWIDTH'(DEPTH - 1)) begin
                state_d = ST_ARB;
            end
        end
    end

    assign in_clear = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
    assign busy     = in_clear;
`else
    assign in_clear = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    // Grants and RAM strobes are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        ram_we     = 1'b0;
        last_gnt_d = last_gnt_q;

        if (rst_n && !in_clear) begin
            if (req0 && req1) begin
                gnt0 = last_gnt_q;
                gnt1 = !last_gnt_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end

        if (rst_n && in_clear) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (gnt0) begin
            ram_we     = we0;
            ram_addr   = addr0;
            ram_din    = din0;
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            ram_we     = we1;
            ram_addr   = addr1;
            ram_din    = din1;
            last_gnt_d = 1'b1;
        end

        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? ram_dout : '0;
    assign rdata1  = rvalid1_q ? ram_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_sp_arbiter.sv
// tb_ram_sp_arbiter: directed self-checking bench for ram_sp_arbiter with a behavioural sync-read RAM.
`default_nettype none

module tb_ram_sp_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          busy;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp3;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_sp_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .req0    (req0),
        .we0     (we0),
        .addr0   (addr0),
        .din0    (din0),
        .gnt0    (gnt0),
        .rvalid0 (rvalid0),
        .rdata0  (rdata0),
        .req1    (req1),
        .we1     (we1),
        .addr1   (addr1),
        .din1    (din1),
        .gnt1    (gnt1),
        .rvalid1 (rvalid1),
        .rdata1  (rdata1),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_we  (ram_we),
        .ram_dout(ram_dout),
        .busy    (busy)
    );

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_dout = '0;
    end

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; din0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
`ifdef RAM_ARB_CLR_EN
        for (int n = 0; n < 20 && busy; n++) cyc();
        chk("clear_done", busy, 1'b0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        req0 = 1'b1; we0 = 1'b1;
        mid();
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
`ifdef RAM_ARB_CLR_EN
        chk("rst_busy", busy, 1'b1);
`else
        chk("rst_busy", busy, 1'b0);
`endif
        idle();
        do_reset();

        // write then read by requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd3; din0 = 32'hDEADBEEF;
        mid();
        chk("w_gnt0", gnt0, 1'b1);
        chk("w_gnt1", gnt1, 1'b0);
        chk("w_ram_we", ram_we, 1'b1);
        chk("w_ram_addr", ram_addr, 3'd3);
        chk("w_ram_din", ram_din, 32'hDEADBEEF);
        cyc();
        we0 = 1'b0;
        mid();
        chk("r_gnt0", gnt0, 1'b1);
        chk("r_ram_we", ram_we, 1'b0);
        chk("w_no_rvalid", rvalid0, 1'b0);
        cyc();
        idle();
        mid();
        chk("r_rvalid0", rvalid0, 1'b1);
        chk("r_rdata0", rdata0, 32'hDEADBEEF);
        chk("r_rvalid1", rvalid1, 1'b0);
        chk("idle_ram_addr", ram_addr, 3'd0);
        chk("idle_gnt0", gnt0, 1'b0);

        // round-robin contention from reset
`ifdef RAM_ARB_CLR_EN
        exp3 = '0;
`else
        exp3 = 32'hDEADBEEF;
`endif
        do_reset();
        req0 = 1'b1; addr0 = 3'd3;
        req1 = 1'b1; addr1 = 3'd5;
        mid();
        chk("rr1_gnt0", gnt0, 1'b1);
        chk("rr1_gnt1", gnt1, 1'b0);
        cyc();
        mid();
        chk("rr2_gnt1", gnt1, 1'b1);
        chk("rr2_gnt0", gnt0, 1'b0);
        chk("rr2_rvalid0", rvalid0, 1'b1);
        chk("rr2_rdata0", rdata0, exp3);
        chk("rr2_rvalid1", rvalid1, 1'b0);
        cyc();
        mid();
        chk("rr3_gnt0", gnt0, 1'b1);
        chk("rr3_rvalid1", rvalid1, 1'b1);
        chk("rr3_rdata1", rdata1, 32'h0);
        chk("rr3_rvalid0", rvalid0, 1'b0);
        cyc();
        mid();
        chk("rr4_gnt1", gnt1, 1'b1);
        chk("rr4_rvalid0", rvalid0, 1'b1);
        chk("rr4_rdata0", rdata0, exp3);
        cyc();
        req1 = 1'b0;
        mid();
        chk("rr5_gnt0", gnt0, 1'b1);
        chk("rr5_rvalid1", rvalid1, 1'b1);
        cyc();
        idle();
        mid();
        chk("rr6_rvalid0", rvalid0, 1'b1);
        chk("rr6_rdata0", rdata0, exp3);

        // requester 1 burst writes then pipelined reads
        cyc();
        for (int i = 0; i < 8; i++) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = AW'(i); din1 = 32'h100 + i;
            mid();
            chk("bw_gnt1", gnt1, 1'b1);
            cyc();
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                req1 = 1'b1; we1 = 1'b0; addr1 = AW'(i);
            end else begin
                idle();
            end
            mid();
            if (i < 8) chk("br_gnt1", gnt1, 1'b1);
            if (i > 0) begin
                chk("br_rvalid1", rvalid1, 1'b1);
                chk("br_rdata1", rdata1, 32'h100 + i - 1);
            end
            cyc();
        end

        // read-after-write across requesters, same address
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; din0 = 32'hA5A5A5A5;
        mid();
        chk("raw_gnt0", gnt0, 1'b1);
        cyc();
        idle();
        req1 = 1'b1; addr1 = 3'd5;
        mid();
        chk("raw_gnt1", gnt1, 1'b1);
        cyc();
        idle();
        mid();
        chk("raw_rvalid1", rvalid1, 1'b1);
        chk("raw_rdata1", rdata1, 32'hA5A5A5A5);

        // reset with a read in flight
        cyc();
        req0 = 1'b1; addr0 = 3'd5;
        mid();
        chk("rf_gnt0", gnt0, 1'b1);
        cyc();
        idle();
        #1;
        chk("rf_rvalid0", rvalid0, 1'b1);
        chk("rf_rdata0", rdata0, 32'hA5A5A5A5);
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("rf_rst_rvalid0", rvalid0, 1'b0);
        chk("rf_rst_gnt0", gnt0, 1'b0);
        chk("rf_rst_gnt1", gnt1, 1'b0);
        cyc();
        chk("rf_rst_rvalid1", rvalid1, 1'b0);
        idle();
        rst_n = 1'b1;
`ifdef RAM_ARB_CLR_EN
        for (int n = 0; n < 20 && busy; n++) cyc();
        chk("rf_clear_done", busy, 1'b0);
`endif
        req0 = 1'b1; req1 = 1'b1;
        mid();
        chk("post_rst_gnt0", gnt0, 1'b1);
        chk("post_rst_gnt1", gnt1, 1'b0);
        cyc();
        mid();
        chk("starve_gnt1", gnt1, 1'b1);
        chk("starve_gnt0", gnt0, 1'b0);
        cyc();
        idle();

`ifdef RAM_ARB_CLR_EN
        // power-up clear with a read waiting
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd7;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("clr_busy", busy, 1'b1);
            chk("clr_ram_we", ram_we, 1'b1);
            chk("clr_ram_addr", ram_addr, AW'(i));
            chk("clr_gnt0", gnt0, 1'b0);
            cyc();
        end
        mid();
        chk("clr_end_busy", busy, 1'b0);
        chk("clr_end_gnt0", gnt0, 1'b1);
        cyc();
        idle();
        mid();
        chk("clr_rvalid0", rvalid0, 1'b1);
        chk("clr_rdata0", rdata0, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
